// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter
// Round-robin arbiter sharing one resource among N requesters. A rotating
// priority pointer picks the first active request at or after the pointer.
// The winner keeps the grant while its request stays high, up to TIMEOUT
// consecutive cycles, after which the grant is forcibly withdrawn. Every
// release is followed by one dead GAP cycle and one IDLE arbitration cycle.
//
// Parameters:
//   N       - number of requesters (2..16)
//   TIMEOUT - max consecutive grant cycles per owner, 0 disables the limit
//   IDW     - width of gnt_id, at least clog2(N)
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous active-high reset
//   req     - level request vector, bit i belongs to requester i
//   gnt     - registered one-hot grant, all-zero when nobody owns the resource
//   gnt_id  - index of the current owner, holds the last owner when idle
//   busy    - high while any grant is active
//   timeout - one-cycle pulse after a forced release
module ring_rr_arbiter #(
   parameter int N       = 8,
   parameter int TIMEOUT = 16,
   parameter int IDW     = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           busy,
   output logic           timeout
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX   = '1;
   localparam logic [PW-1:0] LAST_IDX  = PW'(N - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GRANT = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;

   logic [1:0]    state;
   logic [PW-1:0] ptr;
   logic [PW-1:0] owner;
   logic [PW-1:0] ptrNext;
   logic [PW-1:0] selIdx;
   logic [N-1:0]  selOneHot;
   logic          selValid;
   logic [PW:0]   scanSum;
   logic [CW-1:0] cnt;

   // Find the first active request scanning ptr, ptr+1, ... modulo N.
   // The loop walks the scan order backwards so the last hit written is the
   // one closest to the pointer, which avoids needing a break.
   always_comb begin
      selValid  = 1'b0;
      selIdx    = '0;
      scanSum   = '0;
      selOneHot = '0;
      for (int i = N - 1; i >= 0; i--) begin
         scanSum = {1'b0, ptr} + (PW+1)'(i);
         if (scanSum >= (PW+1)'(N)) begin
            scanSum = scanSum - (PW+1)'(N);
         end
         if (req[scanSum[PW-1:0]]) begin
            selValid = 1'b1;
            selIdx   = scanSum[PW-1:0];
         end
      end
      selOneHot[selIdx] = 1'b1;
   end

   // After a release the departing owner drops to lowest priority by moving
   // the pointer just past it, wrapping from N-1 back to 0.
   always_comb begin
      ptrNext = (owner == LAST_IDX) ? '0 : owner + 1'b1;
   end

   // Arbitration state machine. The grant itself is registered here so the
   // datapath select never glitches. cnt counts cycles the current grant has
   // been visible; it saturates so a disabled timeout can never wrap it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         gnt     <= '0;
         owner   <= '0;
         ptr     <= '0;
         cnt     <= '0;
         timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               timeout <= 1'b0;
               if (selValid) begin
                  gnt   <= selOneHot;
                  owner <= selIdx;
                  cnt   <= CW'(1);
                  state <= GRANT;
               end
            end
            GRANT: begin
               if (!req[owner]) begin
                  gnt   <= '0;
                  ptr   <= ptrNext;
                  state <= GAP;
               end else if ((TIMEOUT != 0) && (cnt == CNT_LIMIT)) begin
                  gnt     <= '0;
                  ptr     <= ptrNext;
                  timeout <= 1'b1;
                  state   <= GAP;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
            GAP: begin
               timeout <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               gnt     <= '0;
               timeout <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   // The owner register is kept after release so gnt_id remembers who last
   // held the resource; high bits beyond the pointer width read zero.
   assign gnt_id = IDW'(owner);
   assign busy   = |gnt;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// tb_ring_rr_arbiter
// Self-checking bench for ring_rr_arbiter. One instance uses the default
// TIMEOUT of 16 and is checked every cycle against a behavioural model
// (owner / cycles-held / blackout counter) plus a table of hand-derived
// checkpoints and a full rotation sequence. A second instance with TIMEOUT=0
// checks that an unlimited grant is never withdrawn or preempted.
module tb_ring_rr_arbiter;

   localparam int N         = 8;
   localparam int IDW       = 3;
   localparam int TIMEOUT_A = 16;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] gnt_id;
   logic           busy;
   logic           timeout;

   logic           rst0;
   logic [N-1:0]   req0;
   logic [N-1:0]   gnt0;
   logic [IDW-1:0] gntId0;
   logic           busy0;
   logic           timeout0;

   int testCount;
   int failCount;

   // Behavioural model state: who owns the resource (-1 for nobody), how
   // many cycles the grant has been visible, the priority start point, and
   // how many more edges must pass before arbitration may happen again.
   int mOwner;
   int mHeld;
   int mPtr;
   int mBlack;
   int mLastId;
   bit mPulse;

   typedef struct {
      logic         rst;
      logic [N-1:0] req;
      int           cycles;
      logic [N-1:0] expGnt;
      logic [2:0]   expId;
      logic         expTo;
   } vecT;

   vecT vecs[40];
   int  nVec;

   ring_rr_arbiter #(.N(N), .TIMEOUT(TIMEOUT_A), .IDW(IDW)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .busy    (busy),
      .timeout (timeout)
   );

   ring_rr_arbiter #(.N(N), .TIMEOUT(0), .IDW(IDW)) dut0 (
      .clk     (clk),
      .rst     (rst0),
      .req     (req0),
      .gnt     (gnt0),
      .gnt_id  (gntId0),
      .busy    (busy0),
      .timeout (timeout0)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int scanFrom(input int start, input logic [N-1:0] r);
      for (int i = 0; i < N; i++) begin
         if (r[(start + i) % N]) return (start + i) % N;
      end
      return -1;
   endfunction

   function automatic int gntIndex(input logic [N-1:0] g);
      for (int i = 0; i < N; i++) begin
         if (g[i]) return i;
      end
      return -1;
   endfunction

   // Advance the model by one rising edge using the inputs the DUT sees.
   task automatic modelEdge();
      mPulse = 1'b0;
      if (rst) begin
         mOwner  = -1;
         mHeld   = 0;
         mPtr    = 0;
         mBlack  = 0;
         mLastId = 0;
      end else if (mOwner >= 0) begin
         if (!req[mOwner] || (mHeld == TIMEOUT_A)) begin
            mPulse = req[mOwner];
            mPtr   = (mOwner + 1) % N;
            mOwner = -1;
            mBlack = 1;
         end else begin
            mHeld++;
         end
      end else if (mBlack > 0) begin
         mBlack--;
      end else if (req != '0) begin
         mOwner  = scanFrom(mPtr, req);
         mLastId = mOwner;
         mHeld   = 1;
      end
   endtask

   // One clock: update the model at the edge, then compare 1 ns later.
   task automatic tick();
      logic [N-1:0] expGnt;
      @(posedge clk);
      modelEdge();
      #1;
      expGnt = (mOwner >= 0) ? (N'(1) << mOwner) : '0;
      checkOutput("model_gnt", 32'(gnt), 32'(expGnt));
      checkOutput("model_gnt_id", 32'(gnt_id), 32'(mLastId));
      checkOutput("model_busy", 32'(busy), 32'(mOwner >= 0));
      checkOutput("model_timeout", 32'(timeout), 32'(mPulse));
      checkOutput("onehot", 32'($countones(gnt) <= 1), 32'd1);
   endtask

   task automatic applyStimulus(input logic r, input logic [N-1:0] q, input int cycles);
      rst = r;
      req = q;
      for (int c = 0; c < cycles; c++) tick();
   endtask

   task automatic addVec(input logic r, input logic [N-1:0] q, input int c,
                         input logic [N-1:0] g, input logic [2:0] id, input logic t);
      vecs[nVec] = '{r, q, c, g, id, t};
      nVec++;
   endtask

   initial begin
      logic [N-1:0] prevGnt;
      int runLen;
      int gapLen;
      int nGrants;
      int nPulses;

      testCount = 0;
      failCount = 0;
      nVec      = 0;
      rst       = 1'b1;
      req       = '0;
      rst0      = 1'b1;
      req0      = '0;
      mOwner    = -1;
      mHeld     = 0;
      mPtr      = 0;
      mBlack    = 0;
      mLastId   = 0;
      mPulse    = 1'b0;

      // Hand-derived checkpoints: {rst, req, cycles, gnt, gnt_id, timeout}
      addVec(1, 8'hFF,  3, 8'h00, 3'd0, 0);
      addVec(0, 8'hFF,  1, 8'h01, 3'd0, 0);
      addVec(0, 8'h00,  1, 8'h00, 3'd0, 0);
      addVec(0, 8'h00,  1, 8'h00, 3'd0, 0);
      addVec(0, 8'h04,  1, 8'h04, 3'd2, 0);
      addVec(0, 8'h04,  4, 8'h04, 3'd2, 0);
      addVec(0, 8'h00,  1, 8'h00, 3'd2, 0);
      addVec(0, 8'hFF,  1, 8'h00, 3'd2, 0);
      addVec(0, 8'hFF,  1, 8'h08, 3'd3, 0);
      addVec(0, 8'hFF,  6, 8'h08, 3'd3, 0);
      addVec(0, 8'hFF,  9, 8'h08, 3'd3, 0);
      addVec(0, 8'hFF,  1, 8'h00, 3'd3, 1);
      addVec(0, 8'hFF,  1, 8'h00, 3'd3, 0);
      addVec(0, 8'hFF,  1, 8'h10, 3'd4, 0);
      addVec(0, 8'hFF,  6, 8'h10, 3'd4, 0);
      addVec(1, 8'hFF,  1, 8'h00, 3'd0, 0);
      addVec(0, 8'h09,  1, 8'h01, 3'd0, 0);
      addVec(0, 8'h00,  1, 8'h00, 3'd0, 0);
      addVec(0, 8'h20,  2, 8'h20, 3'd5, 0);
      addVec(0, 8'h00,  1, 8'h00, 3'd5, 0);
      addVec(0, 8'h21,  2, 8'h01, 3'd0, 0);
      addVec(0, 8'h20,  1, 8'h00, 3'd0, 0);
      addVec(0, 8'h20,  2, 8'h20, 3'd5, 0);
      addVec(0, 8'h80,  1, 8'h00, 3'd5, 0);
      addVec(0, 8'h80,  2, 8'h80, 3'd7, 0);
      addVec(0, 8'h00,  1, 8'h00, 3'd7, 0);
      addVec(0, 8'h82,  2, 8'h02, 3'd1, 0);
      addVec(0, 8'h00,  3, 8'h00, 3'd1, 0);
      addVec(1, 8'h00,  1, 8'h00, 3'd0, 0);
      addVec(0, 8'h04,  1, 8'h04, 3'd2, 0);
      addVec(0, 8'h04, 15, 8'h04, 3'd2, 0);
      addVec(0, 8'h04,  1, 8'h00, 3'd2, 1);
      addVec(0, 8'h04,  1, 8'h00, 3'd2, 0);
      addVec(0, 8'h04,  1, 8'h04, 3'd2, 0);

      for (int k = 0; k < nVec; k++) begin
         applyStimulus(vecs[k].rst, vecs[k].req, vecs[k].cycles);
         checkOutput($sformatf("vec%0d_gnt", k), 32'(gnt), 32'(vecs[k].expGnt));
         checkOutput($sformatf("vec%0d_gnt_id", k), 32'(gnt_id), 32'(vecs[k].expId));
         checkOutput($sformatf("vec%0d_timeout", k), 32'(timeout), 32'(vecs[k].expTo));
         checkOutput($sformatf("vec%0d_busy", k), 32'(busy), 32'(|vecs[k].expGnt));
      end

      // Full rotation under continuous requests: owners 0..7 then 0 again,
      // each held 16 cycles, each separated by exactly two idle cycles.
      applyStimulus(1'b1, 8'h00, 2);
      rst     = 1'b0;
      req     = 8'hFF;
      prevGnt = '0;
      runLen  = 0;
      gapLen  = 0;
      nGrants = 0;
      nPulses = 0;
      for (int c = 0; c < 162; c++) begin
         tick();
         if (timeout) nPulses++;
         if ((gnt != '0) && (prevGnt == '0)) begin
            if (nGrants > 0) checkOutput("rot_gap", 32'(gapLen), 32'd2);
            checkOutput("rot_owner", 32'(gntIndex(gnt)), 32'(nGrants % N));
            nGrants++;
            runLen = 1;
         end else if (gnt != '0) begin
            runLen++;
         end else if (prevGnt != '0) begin
            checkOutput("rot_len", 32'(runLen), 32'd16);
            gapLen = 1;
         end else begin
            gapLen++;
         end
         prevGnt = gnt;
      end
      checkOutput("rot_grants", 32'(nGrants), 32'd9);
      checkOutput("rot_pulses", 32'(nPulses), 32'd9);

      // Randomised traffic with occasional resets, checked by the model
      for (int c = 0; c < 600; c++) begin
         case ($urandom_range(0, 5))
            0: req = N'($urandom);
            1: req = N'(1) << $urandom_range(0, N - 1);
            2: req = '0;
            default: req = req;
         endcase
         rst = ($urandom_range(0, 99) == 0);
         tick();
      end
      applyStimulus(1'b1, 8'h00, 1);
      rst = 1'b0;

      // Unlimited grant: requester 7 keeps the resource for 200 cycles and a
      // later request from requester 1 does not take it away.
      @(negedge clk);
      rst0 = 1'b0;
      req0 = 8'h80;
      for (int c = 0; c < 200; c++) begin
         if (c == 60) req0 = 8'h82;
         tick();
         checkOutput("t0_gnt", 32'(gnt0), 32'h80);
         checkOutput("t0_timeout", 32'(timeout0), 32'd0);
      end
      checkOutput("t0_gnt_id", 32'(gntId0), 32'd7);
      checkOutput("t0_busy", 32'(busy0), 32'd1);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
